// File: rtl/seq_control.sv
// Hardwired control sequencer: T-step micro-sequencing with memory/ALU wait timeout.
// Optional MUL/DIV sequencing enabled by defining MULDIV_EN.
module seq_control #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned MEM_TO = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [DATA_W-1:0] ir,
    input  logic              mem_ready,
    input  logic              alu_done,
    output logic [38:0]       ctrl,
    output logic [2:0]        step,
    output logic              halted,
    output logic              fault,
    output logic              illegal
);

`ifdef MULDIV_EN
    localparam bit MULDIV = 1'b1;
`else
    localparam bit MULDIV = 1'b0;
`endif

    localparam int unsigned CTRL_W = 39;
    localparam int unsigned OP_W   = 5;
    localparam int unsigned CNT_W  = $clog2(MEM_TO + 1);

    localparam int unsigned B_PCOUT = 0,  B_PCIN = 1,   B_MARIN = 2,   B_INCPC = 3;
    localparam int unsigned B_ZIN = 4,    B_ZLOW = 5,   B_ZHIGH = 6,   B_READ = 7;
    localparam int unsigned B_WRITE = 8,  B_MDROUT = 9, B_MDRIN = 10,  B_IRIN = 11;
    localparam int unsigned B_GRA = 12,   B_GRB = 13,   B_GRC = 14,    B_RIN = 15;
    localparam int unsigned B_ROUT = 16,  B_BAOUT = 17, B_COUT = 18,   B_YIN = 19;
    localparam int unsigned B_LOIN = 20,  B_HIIN = 21,  B_CONIN = 22,  B_OUTIN = 23;
    localparam int unsigned B_INOUT = 24, B_BRANCH = 25, B_START = 26, B_ADD = 27;

    localparam logic [OP_W-1:0] OP_LD = 5'd0,  OP_ST = 5'd2,   OP_ADDI = 5'd12;
    localparam logic [OP_W-1:0] OP_MUL = 5'd15, OP_DIV = 5'd16, OP_BR = 5'd18;
    localparam logic [OP_W-1:0] OP_IN = 5'd22, OP_OUT = 5'd23, OP_NOP = 5'd24;
    localparam logic [OP_W-1:0] OP_HALT = 5'd25;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_HALT, S_FAULT} state_t;

    state_t            state_q, state_nxt;
    logic [2:0]        step_nxt;
    logic [OP_W-1:0]   op_q, op_nxt;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt;
    logic              rdy, adv;
    logic              unused_ir;

    assign unused_ir = ^ir[DATA_W-OP_W-1:0];

    function automatic logic is_alu(input logic [OP_W-1:0] op);
        return (op >= 5'd3 && op <= 5'd10) || op == OP_ADDI;
    endfunction

    function automatic logic is_muldiv(input logic [OP_W-1:0] op);
        return MULDIV && (op == OP_MUL || op == OP_DIV);
    endfunction

    function automatic logic is_mem(input logic [OP_W-1:0] op);
        return op == OP_LD || op == OP_ST;
    endfunction

    function automatic logic is_defined(input logic [OP_W-1:0] op);
        return is_alu(op) || is_muldiv(op) || is_mem(op) || op == OP_BR || op == OP_IN
            || op == OP_OUT || op == OP_NOP || op == OP_HALT;
    endfunction

    // ALU function strobe index within ctrl
    function automatic int unsigned alu_bit(input logic [OP_W-1:0] op);
        case (op)
            5'd4:    return 28;
            5'd5:    return 35;
            5'd6:    return 36;
            5'd7:    return 31;
            5'd8:    return 32;
            5'd9:    return 33;
            5'd10:   return 34;
            OP_MUL:  return 29;
            OP_DIV:  return 30;
            default: return B_ADD;
        endcase
    endfunction

    function automatic logic [2:0] last_step(input logic [OP_W-1:0] op);
        if (is_alu(op))           return 3'd5;
        else if (is_muldiv(op))   return 3'd6;
        else if (is_mem(op))      return 3'd7;
        else if (op == OP_BR)     return 3'd6;
        else                      return 3'd3;
    endfunction

    function automatic logic is_wait(input logic [2:0] t, input logic [OP_W-1:0] op);
        return (t == 3'd1) || (t == 3'd6 && op == OP_LD) || (t == 3'd7 && op == OP_ST)
            || (t == 3'd4 && is_muldiv(op));
    endfunction

    function automatic logic [CTRL_W-1:0] decode(input state_t st, input logic [2:0] t,
                                                 input logic [OP_W-1:0] op);
        logic [CTRL_W-1:0] c;
        c = '0;
        if (st == S_EXEC) begin
            case (t)
                3'd0: begin c[B_PCOUT] = 1'b1; c[B_MARIN] = 1'b1; c[B_INCPC] = 1'b1; c[B_ZIN] = 1'b1; end
                3'd1: begin c[B_ZLOW] = 1'b1; c[B_PCIN] = 1'b1; c[B_READ] = 1'b1; end
                3'd2: begin c[B_MDROUT] = 1'b1; c[B_IRIN] = 1'b1; end
                3'd3: begin
                    if (is_alu(op) || is_muldiv(op)) begin c[B_GRB] = 1'b1; c[B_ROUT] = 1'b1; c[B_YIN] = 1'b1; end
                    else if (is_mem(op)) begin c[B_GRB] = 1'b1; c[B_BAOUT] = 1'b1; c[B_YIN] = 1'b1; end
                    else if (op == OP_BR) begin c[B_GRA] = 1'b1; c[B_ROUT] = 1'b1; c[B_CONIN] = 1'b1; end
                    else if (op == OP_IN) begin c[B_INOUT] = 1'b1; c[B_GRA] = 1'b1; c[B_RIN] = 1'b1; end
                    else if (op == OP_OUT) begin c[B_GRA] = 1'b1; c[B_ROUT] = 1'b1; c[B_OUTIN] = 1'b1; end
                end
                3'd4: begin
                    if (is_alu(op) || is_muldiv(op)) begin
                        c[alu_bit(op)] = 1'b1;
                        c[B_ZIN]       = 1'b1;
                        // ADDI takes its second operand from the immediate field
                        if (op == OP_ADDI) c[B_COUT] = 1'b1;
                        else begin c[B_GRC] = 1'b1; c[B_ROUT] = 1'b1; end
                        if (is_muldiv(op)) c[B_START] = 1'b1;
                    end
                    else if (is_mem(op)) begin c[B_COUT] = 1'b1; c[B_ADD] = 1'b1; c[B_ZIN] = 1'b1; end
                    else if (op == OP_BR) begin c[B_PCOUT] = 1'b1; c[B_YIN] = 1'b1; end
                end
                3'd5: begin
                    if (is_alu(op)) begin c[B_ZLOW] = 1'b1; c[B_GRA] = 1'b1; c[B_RIN] = 1'b1; end
                    else if (is_muldiv(op)) begin c[B_ZLOW] = 1'b1; c[B_LOIN] = 1'b1; end
                    else if (is_mem(op)) begin c[B_ZLOW] = 1'b1; c[B_MARIN] = 1'b1; end
                    else if (op == OP_BR) begin c[B_COUT] = 1'b1; c[B_ADD] = 1'b1; c[B_ZIN] = 1'b1; end
                end
                3'd6: begin
                    if (is_muldiv(op)) begin c[B_ZHIGH] = 1'b1; c[B_HIIN] = 1'b1; end
                    else if (op == OP_LD) c[B_READ] = 1'b1;
                    else if (op == OP_ST) begin c[B_GRA] = 1'b1; c[B_ROUT] = 1'b1; c[B_MDRIN] = 1'b1; end
                    else if (op == OP_BR) begin c[B_ZLOW] = 1'b1; c[B_BRANCH] = 1'b1; end
                end
                default: begin
                    if (op == OP_LD) begin c[B_MDROUT] = 1'b1; c[B_GRA] = 1'b1; c[B_RIN] = 1'b1; end
                    else if (op == OP_ST) c[B_WRITE] = 1'b1;
                end
            endcase
        end
        return c;
    endfunction

    // Next-state, step sequencing and wait-timeout
    always_comb begin
        state_nxt = state_q;
        step_nxt  = step;
        op_nxt    = op_q;
        cnt_nxt   = cnt_q;
        rdy       = 1'b0;
        adv       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_nxt = S_EXEC;
                    step_nxt  = '0;
                    cnt_nxt   = '0;
                end
            end
            S_EXEC: begin
                if (step == 3'd2) op_nxt = ir[DATA_W-1 -: OP_W];
                adv = 1'b1;
                if (is_wait(step, op_q)) begin
                    rdy = (step == 3'd4) ? alu_done : mem_ready;
                    adv = rdy;
                    if (rdy) cnt_nxt = '0;
                    else if (cnt_q == CNT_W'(MEM_TO - 1)) begin
                        state_nxt = S_FAULT;
                        step_nxt  = '0;
                        cnt_nxt   = '0;
                    end
                    else cnt_nxt = cnt_q + CNT_W'(1);
                end
                if (adv) begin
                    if (step == 3'd0 && !run) state_nxt = S_IDLE;
                    else if (step == 3'd3 && op_q == OP_HALT) begin
                        state_nxt = S_HALT;
                        step_nxt  = '0;
                    end
                    else if (step == last_step(op_q)) step_nxt = '0;
                    else step_nxt = step + 3'd1;
                end
            end
            default: ;
        endcase
    end

    // State register; outputs are registered decodes of the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            step    <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            ctrl    <= '0;
            halted  <= 1'b0;
            fault   <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state_q <= state_nxt;
            step    <= step_nxt;
            op_q    <= op_nxt;
            cnt_q   <= cnt_nxt;
            ctrl    <= decode(state_nxt, step_nxt, op_nxt);
            halted  <= (state_nxt == S_HALT);
            fault   <= (state_nxt == S_FAULT);
            illegal <= (state_nxt == S_EXEC) && (step_nxt == 3'd3) && !is_defined(op_nxt);
        end
    end

endmodule

// File: tb/tb_seq_control.sv
// Self-checking bench for seq_control: vector table, micro-program model with random waits,
// and directed corner sequences (timeout, halt, reset mid-wait, run gating).
module tb_seq_control;

    localparam int unsigned TB_W  = 32;
    localparam int unsigned LOW_W = TB_W - 5;
`ifdef MULDIV_EN
    localparam int unsigned TB_TO = 40;
    localparam bit          MD    = 1'b1;
`else
    localparam int unsigned TB_TO = 15;
    localparam bit          MD    = 1'b0;
`endif

    localparam logic [38:0] C_PCOUT = 39'(1) << 0,   C_PCIN = 39'(1) << 1,   C_MARIN = 39'(1) << 2;
    localparam logic [38:0] C_INCPC = 39'(1) << 3,   C_ZIN = 39'(1) << 4,    C_ZLOW = 39'(1) << 5;
    localparam logic [38:0] C_ZHIGH = 39'(1) << 6,   C_READ = 39'(1) << 7,   C_WRITE = 39'(1) << 8;
    localparam logic [38:0] C_MDROUT = 39'(1) << 9,  C_MDRIN = 39'(1) << 10, C_IRIN = 39'(1) << 11;
    localparam logic [38:0] C_GRA = 39'(1) << 12,    C_GRB = 39'(1) << 13,   C_GRC = 39'(1) << 14;
    localparam logic [38:0] C_RIN = 39'(1) << 15,    C_ROUT = 39'(1) << 16,  C_BAOUT = 39'(1) << 17;
    localparam logic [38:0] C_COUT = 39'(1) << 18,   C_YIN = 39'(1) << 19,   C_LOIN = 39'(1) << 20;
    localparam logic [38:0] C_HIIN = 39'(1) << 21,   C_CONIN = 39'(1) << 22, C_OUTIN = 39'(1) << 23;
    localparam logic [38:0] C_INOUT = 39'(1) << 24,  C_BRANCH = 39'(1) << 25, C_START = 39'(1) << 26;
    localparam logic [38:0] C_ADD = 39'(1) << 27,    C_SUB = 39'(1) << 28,   C_MUL = 39'(1) << 29;
    localparam logic [38:0] C_DIV = 39'(1) << 30,    C_SHR = 39'(1) << 31,   C_SHL = 39'(1) << 32;
    localparam logic [38:0] C_ROR = 39'(1) << 33,    C_ROL = 39'(1) << 34,   C_AND = 39'(1) << 35;
    localparam logic [38:0] C_OR = 39'(1) << 36;
    localparam logic [38:0] F0 = C_PCOUT | C_MARIN | C_INCPC | C_ZIN;

    logic            clk, reset, run, mem_ready, alu_done;
    logic [TB_W-1:0] ir;
    logic [38:0]     ctrl;
    logic [2:0]      step;
    logic            halted, fault, illegal;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0]  t;
        logic [38:0] c;
        logic        ill;
        logic        wt;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [4:0] op;
        int         wstep;
        int         d;
        int         len;
        int         ill;
    } vec_t;
    vec_t vt[$];

    seq_control #(.DATA_W(TB_W), .MEM_TO(TB_TO)) dut (
        .clk(clk), .reset(reset), .run(run), .ir(ir), .mem_ready(mem_ready),
        .alu_done(alu_done), .ctrl(ctrl), .step(step), .halted(halted),
        .fault(fault), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] obs();
        return 64'({fault, halted, illegal, step, ctrl});
    endfunction

    function automatic logic [63:0] ex(input logic f, input logic h, input logic i,
                                       input logic [2:0] t, input logic [38:0] c);
        return 64'({f, h, i, t, c});
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    function automatic void push(input logic [2:0] t, input logic [38:0] c, input logic ill,
                                 input int waits);
        for (int i = 0; i < waits; i++) exp_q.push_back('{t, c, ill, 1'b1});
        exp_q.push_back('{t, c, ill, 1'b0});
    endfunction

    // Micro-program table: expected strobe words per step for one instruction
    function automatic void model(input logic [4:0] op, input int df, input int dx);
        logic [38:0] fn;
        push(3'd0, F0, 1'b0, 0);
        push(3'd1, C_ZLOW | C_PCIN | C_READ, 1'b0, df);
        push(3'd2, C_MDROUT | C_IRIN, 1'b0, 0);
        case (op)
            5'd3: fn = C_ADD;   5'd4: fn = C_SUB;   5'd5: fn = C_AND;  5'd6: fn = C_OR;
            5'd7: fn = C_SHR;   5'd8: fn = C_SHL;   5'd9: fn = C_ROR;  5'd10: fn = C_ROL;
            5'd15: fn = C_MUL;  5'd16: fn = C_DIV;  default: fn = C_ADD;
        endcase
        if ((op >= 5'd3 && op <= 5'd10) || op == 5'd12) begin
            push(3'd3, C_GRB | C_ROUT | C_YIN, 1'b0, 0);
            push(3'd4, ((op == 5'd12) ? C_COUT : (C_GRC | C_ROUT)) | fn | C_ZIN, 1'b0, 0);
            push(3'd5, C_ZLOW | C_GRA | C_RIN, 1'b0, 0);
        end else if (MD && (op == 5'd15 || op == 5'd16)) begin
            push(3'd3, C_GRB | C_ROUT | C_YIN, 1'b0, 0);
            push(3'd4, C_GRC | C_ROUT | fn | C_START | C_ZIN, 1'b0, dx);
            push(3'd5, C_ZLOW | C_LOIN, 1'b0, 0);
            push(3'd6, C_ZHIGH | C_HIIN, 1'b0, 0);
        end else if (op == 5'd0 || op == 5'd2) begin
            push(3'd3, C_GRB | C_BAOUT | C_YIN, 1'b0, 0);
            push(3'd4, C_COUT | C_ADD | C_ZIN, 1'b0, 0);
            push(3'd5, C_ZLOW | C_MARIN, 1'b0, 0);
            if (op == 5'd0) begin
                push(3'd6, C_READ, 1'b0, dx);
                push(3'd7, C_MDROUT | C_GRA | C_RIN, 1'b0, 0);
            end else begin
                push(3'd6, C_GRA | C_ROUT | C_MDRIN, 1'b0, 0);
                push(3'd7, C_WRITE, 1'b0, dx);
            end
        end else if (op == 5'd18) begin
            push(3'd3, C_GRA | C_ROUT | C_CONIN, 1'b0, 0);
            push(3'd4, C_PCOUT | C_YIN, 1'b0, 0);
            push(3'd5, C_COUT | C_ADD | C_ZIN, 1'b0, 0);
            push(3'd6, C_ZLOW | C_BRANCH, 1'b0, 0);
        end else if (op == 5'd22) push(3'd3, C_INOUT | C_GRA | C_RIN, 1'b0, 0);
        else if (op == 5'd23) push(3'd3, C_GRA | C_ROUT | C_OUTIN, 1'b0, 0);
        else if (op == 5'd24 || op == 5'd25) push(3'd3, '0, 1'b0, 0);
        else push(3'd3, '0, 1'b1, 0);
    endfunction

    // Plays one instruction from T0, comparing every cycle against the model
    task automatic run_instr(input logic [4:0] op, input int df, input int dx);
        exp_t e;
        exp_q.delete();
        model(op, df, dx);
        ir = {op, LOW_W'($urandom)};
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            mem_ready = !e.wt;
            alu_done  = !e.wt;
            chk($sformatf("op%0d_t%0d", op, e.t), obs(), ex(1'b0, 1'b0, e.ill, e.t, e.c));
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        alu_done  = 1'b1;
    endtask

    // Table vector: measure instruction length and illegal pulses
    task automatic run_vec(input int idx, input vec_t v);
        int waited, len, ill;
        waited = 0; len = 0; ill = 0;
        ir = {v.op, LOW_W'($urandom)};
        do begin
            if (v.wstep != 0 && step == 3'(v.wstep) && waited < v.d) begin
                mem_ready = 1'b0; alu_done = 1'b0; waited++;
            end else begin
                mem_ready = 1'b1; alu_done = 1'b1;
            end
            if (illegal) ill++;
            @(posedge clk); #1;
            len++;
        end while (step != 3'd0 && len < 200);
        mem_ready = 1'b1; alu_done = 1'b1;
        chk($sformatf("vec%0d_len", idx), 64'(len), 64'(v.len));
        chk($sformatf("vec%0d_ill", idx), 64'(ill), 64'(v.ill));
    endtask

    initial begin
        int n;
        logic [4:0] rop;
        reset = 1'b0; run = 1'b1; ir = '0; mem_ready = 1'b1; alu_done = 1'b1;

        #12;
        chk("reset_async", obs(), 64'(0));
        @(posedge clk); #1;
        chk("reset_hold", obs(), 64'(0));
        reset = 1'b1; #1;
        chk("idle", obs(), 64'(0));
        @(posedge clk); #1;

        // Fetch strobes then ADD: 6 cycles back to T0
        run_instr(5'd3, 0, 0);
        chk("add_next_t0", obs(), ex(1'b0, 1'b0, 1'b0, 3'd0, F0));

        vt.push_back('{5'd3, 0, 0, 6, 0});
        vt.push_back('{5'd4, 1, 2, 8, 0});
        vt.push_back('{5'd12, 0, 0, 6, 0});
        vt.push_back('{5'd0, 6, 3, 11, 0});
        vt.push_back('{5'd0, 6, int'(TB_TO) - 1, 8 + int'(TB_TO) - 1, 0});
        vt.push_back('{5'd2, 7, 2, 10, 0});
        vt.push_back('{5'd18, 0, 0, 7, 0});
        vt.push_back('{5'd22, 1, int'(TB_TO) - 1, 4 + int'(TB_TO) - 1, 0});
        vt.push_back('{5'd23, 0, 0, 4, 0});
        vt.push_back('{5'd24, 0, 0, 4, 0});
        vt.push_back('{5'd31, 0, 0, 4, 1});
        vt.push_back('{5'd1, 0, 0, 4, 1});
`ifdef MULDIV_EN
        vt.push_back('{5'd15, 4, 5, 12, 0});
        vt.push_back('{5'd16, 4, 0, 7, 0});
`else
        vt.push_back('{5'd15, 0, 0, 4, 1});
        vt.push_back('{5'd16, 0, 0, 4, 1});
`endif
        foreach (vt[i]) run_vec(i, vt[i]);

        // Directed: LD with 3 wait cycles at T6, illegal opcode 31, MUL behaviour
        run_instr(5'd0, 0, 3);
        run_instr(5'd31, 0, 0);
        run_instr(5'd15, 0, MD ? 31 : 0);

        // Random instruction stream against the model
        repeat (40) begin
            rop = 5'($urandom);
            if (rop == 5'd25) rop = 5'd24;
            run_instr(rop,
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TB_TO - 1)) : 0,
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TB_TO - 1)) : 0);
        end

        // run=0 at T0 drops to IDLE, run=1 resumes fetch
        run = 1'b0;
        chk("run0_t0", obs(), ex(1'b0, 1'b0, 1'b0, 3'd0, F0));
        @(posedge clk); #1;
        chk("run0_idle", obs(), 64'(0));
        @(posedge clk); #1;
        chk("run0_stay", obs(), 64'(0));
        run = 1'b1;
        @(posedge clk); #1;
        chk("run1_t0", obs(), ex(1'b0, 1'b0, 1'b0, 3'd0, F0));

        // Reset while LD waits at T6
        ir = {5'd0, LOW_W'($urandom)};
        n = 0;
        while (step != 3'd6 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("ld_wait", obs(), ex(1'b0, 1'b0, 1'b0, 3'd6, C_READ));
        reset = 1'b0; #1;
        chk("midop_rst", obs(), 64'(0));
        @(posedge clk); #1;
        chk("midop_rst_edge", obs(), 64'(0));
        reset = 1'b1; mem_ready = 1'b1; #1;
        chk("midop_idle", obs(), 64'(0));
        @(posedge clk); #1;
        chk("midop_restart", obs(), ex(1'b0, 1'b0, 1'b0, 3'd0, F0));

        // Fetch read never completes: FAULT after TB_TO waits
        mem_ready = 1'b0;
        @(posedge clk); #1;
        n = 0;
        while (step == 3'd1 && !fault && n < int'(TB_TO) + 5) begin
            @(posedge clk); #1; n++;
        end
        chk("fault_waits", 64'(n), 64'(TB_TO));
        chk("fault_state", obs(), ex(1'b1, 1'b0, 1'b0, 3'd0, '0));
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("fault_sticky", obs(), ex(1'b1, 1'b0, 1'b0, 3'd0, '0));
        reset = 1'b0; #1;
        chk("fault_clear", obs(), 64'(0));
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // HALT is permanent until reset
        run_instr(5'd25, 0, 0);
        chk("halt", obs(), ex(1'b0, 1'b1, 1'b0, 3'd0, '0));
        repeat (4) begin
            run = 1'($urandom); mem_ready = 1'($urandom);
            @(posedge clk); #1;
            chk("halt_sticky", obs(), ex(1'b0, 1'b1, 1'b0, 3'd0, '0));
        end
        reset = 1'b0; #1;
        chk("halt_clear", obs(), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
